// File: rtl/ps2_key_injector.sv
// ps2_key_injector
//   Transmit side of the 11-bit ps2_key event interface
//   {toggle[10], press[9], extended[8], scancode[7:0]}. Forwards live host
//   key events and merges in queued synthetic events. After each injected
//   event it holds off for GAP clocks, so a slow matrix scan sees every
//   press and every release.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high reset
//   host_key  live ps2_key from the HPS; a toggle of bit 10 marks a new event
//   wr        single-cycle strobe that enqueues wr_data
//   wr_data   {press, ext, scancode[7:0]}
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds no entries
//   overflow  sticky: wr seen while full (cleared only by reset)
//   ps2_key   merged event stream to the keyboard matrix block
//   busy      high while injecting/holding off or while the FIFO is non-empty
module ps2_key_injector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP   = 640000,
  parameter int unsigned GAP_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] host_key,
  input  logic        wr,
  input  logic [9:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic [10:0] ps2_key,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [10:0]      key_q, key_d;
  logic             primed_q, primed_d;
  logic             host_flag_q, host_flag_d;

  logic [9:0]       mem [DEPTH];

  logic             host_edge;
  logic             push;
  logic             pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;
  assign ps2_key  = key_q;
  assign busy     = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    key_d       = key_q;
    primed_d    = primed_q;
    host_flag_d = host_flag_q;

    host_edge = primed_q && (host_key[10] != host_flag_q);
    // No bypass: fullness and emptiness are judged on the registered count only.
    push      = wr && !full;
    pop       = (state_q == IDLE) && !empty && !host_edge;

    if (wr && full) begin
      overflow_d = 1'b1;
    end

    // The first post-reset edge only captures the host flag, so a flag that
    // is already high at reset exit is not mistaken for a new event.
    if (!primed_q) begin
      primed_d    = 1'b1;
      host_flag_d = host_key[10];
    end else if (host_edge) begin
      host_flag_d = host_key[10];
      key_d       = {~key_q[10], host_key[9:0]};
    end else if (pop) begin
      key_d       = {~key_q[10], mem[rd_ptr_q]};
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = WAIT;
          gap_d   = GAP_W'(GAP - 1);
        end
      end
      WAIT: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      key_q       <= '0;
      primed_q    <= 1'b0;
      host_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      key_q       <= key_d;
      primed_q    <= primed_d;
      host_flag_q <= host_flag_d;
    end
  end

  // Storage needs no reset: entries are only read behind the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ps2_key_injector.sv
module tb_ps2_key_injector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          cyc     = 0;
  int          last_b  = 0;

  // Instance A: GAP=4
  logic        rst_a, wr_a, full_a, empty_a, ovf_a, busy_a;
  logic [10:0] hk_a, key_a;
  logic [9:0]  wd_a;

  // Instance B: GAP=10
  logic        rst_b, wr_b, full_b, empty_b, ovf_b, busy_b;
  logic [10:0] hk_b, key_b;
  logic [9:0]  wd_b;

  ps2_key_injector #(.DEPTH(8), .GAP(4), .GAP_W(24)) dut_a (
    .clk(clk), .reset(rst_a), .host_key(hk_a), .wr(wr_a), .wr_data(wd_a),
    .full(full_a), .empty(empty_a), .overflow(ovf_a), .ps2_key(key_a), .busy(busy_a)
  );

  ps2_key_injector #(.DEPTH(8), .GAP(10), .GAP_W(24)) dut_b (
    .clk(clk), .reset(rst_b), .host_key(hk_b), .wr(wr_b), .wr_data(wd_b),
    .full(full_b), .empty(empty_b), .overflow(ovf_b), .ps2_key(key_b), .busy(busy_b)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  wd;
    logic [10:0] hk;
    logic [10:0] key;
    logic        busy;
    logic        empty;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for the next change on key_b, then checks value and
  // distance in clocks from the previous injected event.
  task automatic wait_emit_b(input logic [10:0] exp_key, input int exp_gap, input string nm);
    logic [10:0] prev;
    int          n;
    prev = key_b;
    n    = 0;
    while (key_b == prev && n < 40) begin
      tick();
      n++;
    end
    check({nm, "_seen"}, 32'(key_b != prev), 32'd1);
    check({nm, "_key"}, 32'(key_b), 32'(exp_key));
    check({nm, "_gap"}, 32'(cyc - last_b), 32'(exp_gap));
    last_b = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] prev;
    int          chg;

    // Injection pair on A (GAP=4): toggles at rows 1 and 6, busy drops at row 10.
    vecs[0]  = '{1'b1, 10'h21C, 11'h21C, 11'h61C, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 10'h01C, 11'h21C, 11'h21C, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 10'h000, 11'h21C, 11'h21C, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 10'h000, 11'h21C, 11'h21C, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 10'h000, 11'h21C, 11'h21C, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 10'h000, 11'h21C, 11'h21C, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 10'h000, 11'h21C, 11'h41C, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 10'h000, 11'h21C, 11'h41C, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 10'h000, 11'h21C, 11'h41C, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 10'h000, 11'h21C, 11'h41C, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 10'h000, 11'h21C, 11'h41C, 1'b0, 1'b1};

    rst_a = 1'b1; rst_b = 1'b1;
    hk_a  = 11'h400; hk_b = 11'h000;
    wr_a  = 1'b0; wd_a = '0;
    wr_b  = 1'b0; wd_b = '0;
    #1;
    check("rst_key", 32'(key_a), 32'h0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);

    // Priming with host flag already high
    tick(); tick();
    rst_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("prime_key[%0d]", i), 32'(key_a), 32'h0);
    end
    hk_a = 11'h21C;
    tick();
    check("prime_first_edge", 32'(key_a), 32'h61C);

    for (int i = 0; i < 11; i++) begin
      wr_a = vecs[i].wr;
      wd_a = vecs[i].wd;
      hk_a = vecs[i].hk;
      tick();
      check($sformatf("inj_key[%0d]", i), 32'(key_a), 32'(vecs[i].key));
      check($sformatf("inj_busy[%0d]", i), 32'(busy_a), 32'(vecs[i].busy));
      check($sformatf("inj_empty[%0d]", i), 32'(empty_a), 32'(vecs[i].empty));
    end
    wr_a = 1'b0;

    // Collision: host edge in the cycle IDLE would pop 229
    wr_a = 1'b1; wd_a = 10'h229;
    tick();
    wr_a = 1'b0; hk_a = 11'h676;
    tick();
    check("coll_host_first", 32'(key_a), 32'h276);
    tick();
    check("coll_inject_next", 32'(key_a), 32'h629);
    repeat (5) tick();
    check("coll_busy_done", 32'(busy_a), 32'd0);

    // Reset during WAIT with 3 entries queued
    for (int i = 0; i < 4; i++) begin
      wr_a = 1'b1; wd_a = 10'h011 + 10'(i);
      tick();
    end
    wr_a = 1'b0;
    check("rw_pre_key", 32'(key_a), 32'h011);
    check("rw_pre_busy", 32'(busy_a), 32'd1);
    rst_a = 1'b1;
    #1;
    check("rw_key", 32'(key_a), 32'h0);
    check("rw_empty", 32'(empty_a), 32'd1);
    check("rw_busy", 32'(busy_a), 32'd0);
    check("rw_ovf", 32'(ovf_a), 32'd0);
    tick();
    rst_a = 1'b0;
    chg = 0;
    repeat (10) begin
      tick();
      if (key_a != 11'h0) chg++;
    end
    check("rw_quiet", 32'(chg), 32'd0);
    check("rw_empty_after", 32'(empty_a), 32'd1);

    // Overflow on B (GAP=10): 10 back-to-back writes
    rst_b = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      wr_b = 1'b1; wd_b = 10'h100 + 10'(i);
      tick();
      if (i == 1) begin
        check("ovf_first_emit", 32'(key_b), 32'h500);
        last_b = cyc;
      end
    end
    wr_b = 1'b0;
    check("ovf_full", 32'(full_b), 32'd1);
    check("ovf_flag", 32'(ovf_b), 32'd1);
    for (int k = 0; k < 8; k++) begin
      wait_emit_b({1'(k % 2), 10'h101 + 10'(k)}, 11, $sformatf("ovf_emit%0d", k));
    end
    prev = key_b;
    chg  = 0;
    repeat (30) begin
      tick();
      if (key_b != prev) chg++;
      prev = key_b;
    end
    check("ovf_tenth_dropped", 32'(chg), 32'd0);
    check("ovf_empty_end", 32'(empty_b), 32'd1);
    check("ovf_busy_end", 32'(busy_b), 32'd0);
    check("ovf_sticky", 32'(ovf_b), 32'd1);

    // Host edge during WAIT on B
    wr_b = 1'b1; wd_b = 10'h0AA;
    tick();
    wd_b = 10'h0BB;
    tick();
    wr_b = 1'b0;
    check("hw_first_inject", 32'(key_b), 32'h0AA);
    last_b = cyc;
    tick(); tick();
    hk_b = 11'h4F0;
    tick();
    check("hw_host_fwd", 32'(key_b), 32'h4F0);
    wait_emit_b(11'h0BB, 11, "hw_next_inject");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
